i2c_target_regs: RTL and testbench

I2C target (responder) with a small register file: the other end of the robot controller's I2C master bus. It lets an external I2C controller read and write a bank of byte registers, and lets on-chip logic read and update the same bank. It sits beside the I2C master on the shared open-drain SDA/SCL pads. It never drives SCL and never drives SDA high.

---
 rtl/i2c_target_regs.sv | 278 +++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target with a small byte register bank shared between the bus and on-chip logic.
// SCL is only ever observed and SDA is only ever pulled low (open-drain).
module i2c_target_regs #(
   parameter logic [6:0] ADDR  = 7'h42,
   parameter int         NREGS = 8,
   localparam int        IW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          sda_oe,
   input  logic          sys_wr_en,
   input  logic [IW-1:0] sys_wr_idx,
   input  logic [7:0]    sys_wr_data,
   input  logic [IW-1:0] sys_rd_idx,
   output logic [7:0]    sys_rd_data,
   output logic          i2c_wr_stb,
   output logic [IW-1:0] i2c_wr_idx,
   output logic          busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   // [0],[1] synchronize; [2] is the previous synchronized level for edge detection
   logic [2:0]    scl_sync_q;
   logic [2:0]    sda_sync_q;

   state_t        state_q,   state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q,   shift_d;
   logic [IW-1:0] ptr_q,     ptr_d;
   logic          first_q,   first_d;    // next write byte is the pointer
   logic          rw_q,      rw_d;
   logic          ack_drv_q, ack_drv_d;  // ACK slot: 0 = awaiting pulldown fall, 1 = pulling
   logic          busy_q,    busy_d;
   logic          sda_oe_q,  sda_oe_d;
   logic          wr_stb_q,  wr_stb_d;
   logic [IW-1:0] wr_idx_q,  wr_idx_d;

   logic          i2c_we;
   logic [7:0]    i2c_wdata;
   logic [7:0]    regs [NREGS];

   logic          sda_s;
   logic          scl_rise;
   logic          scl_fall;
   logic          start_det;
   logic          stop_det;
   logic [7:0]    rx_byte;
   logic [IW-1:0] ptr_inc;

   // Pad synchronizers, preset to the idle (released) bus level
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_in};
         sda_sync_q <= {sda_sync_q[1:0], sda_in};
      end
   end

   assign sda_s     = sda_sync_q[1];
   assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
   // START/STOP require SCL stable high across the SDA edge
   assign start_det = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
   assign stop_det  = scl_sync_q[1] & scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];
   assign rx_byte   = {shift_q[6:0], sda_s};
   assign ptr_inc   = ptr_q + 1'b1;

   // Protocol state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         first_q   <= 1'b0;
         rw_q      <= 1'b0;
         ack_drv_q <= 1'b0;
         busy_q    <= 1'b0;
         sda_oe_q  <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_idx_q  <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         first_q   <= first_d;
         rw_q      <= rw_d;
         ack_drv_q <= ack_drv_d;
         busy_q    <= busy_d;
         sda_oe_q  <= sda_oe_d;
         wr_stb_q  <= wr_stb_d;
         wr_idx_q  <= wr_idx_d;
      end
   end

   // Next-state logic; START and STOP override whatever the current state is doing
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      first_d   = first_q;
      rw_d      = rw_q;
      ack_drv_d = ack_drv_q;
      busy_d    = busy_q;
      sda_oe_d  = sda_oe_q;
      wr_stb_d  = 1'b0;
      wr_idx_d  = wr_idx_q;
      i2c_we    = 1'b0;
      i2c_wdata = rx_byte;

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         ack_drv_d = 1'b0;
      end else if (stop_det) begin
         state_d   = ST_IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         ack_drv_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sda_oe_d = 1'b0;
            end
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (rx_byte[7:1] == ADDR) begin
                        state_d   = ST_ADDR_ACK;
                        rw_d      = rx_byte[0];
                        ack_drv_d = 1'b0;
                     end else begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_drv_q) begin
                     ack_drv_d = 1'b1;
                     sda_oe_d  = 1'b1;
                     busy_d    = 1'b1;
                  end else begin
                     ack_drv_d = 1'b0;
                     bit_cnt_d = '0;
                     if (rw_q) begin
                        // Release the ACK and present the first read bit on the same fall
                        state_d   = ST_RD_BYTE;
                        sda_oe_d  = ~regs[ptr_q][7];
                        shift_d   = {regs[ptr_q][6:0], 1'b0};
                        bit_cnt_d = 4'd1;
                     end else begin
                        state_d  = ST_WR_BYTE;
                        sda_oe_d = 1'b0;
                        first_d  = 1'b1;
                     end
                  end
               end
            end
            ST_WR_BYTE: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     state_d   = ST_WR_ACK;
                     ack_drv_d = 1'b0;
                     if (first_q) begin
                        ptr_d   = rx_byte[IW-1:0];
                        first_d = 1'b0;
                     end else begin
                        i2c_we   = 1'b1;
                        wr_stb_d = 1'b1;
                        wr_idx_d = ptr_q;
                        ptr_d    = ptr_inc;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!ack_drv_q) begin
                     ack_drv_d = 1'b1;
                     sda_oe_d  = 1'b1;
                  end else begin
                     ack_drv_d = 1'b0;
                     sda_oe_d  = 1'b0;
                     state_d   = ST_WR_BYTE;
                  end
               end
            end
            ST_RD_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     sda_oe_d  = ~shift_q[7];
                     shift_d   = {shift_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  ptr_d = ptr_inc;
                  if (!sda_s) begin
                     // Snapshot the next byte now so later register updates cannot tear it
                     state_d   = ST_RD_BYTE;
                     shift_d   = regs[ptr_inc];
                     bit_cnt_d = '0;
                  end else begin
                     state_d = ST_IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            ST_IGNORE: begin
               sda_oe_d = 1'b0;
            end
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   // One storage byte per index; a bus commit beats a same-index on-chip write
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [IW-1:0] IDX = IW'(gi);
      logic [7:0] byte_q;

      // Register byte update
      always_ff @(posedge clk) begin
         if (reset) begin
            byte_q <= '0;
         end else if (i2c_we && (ptr_q == IDX)) begin
            byte_q <= i2c_wdata;
         end else if (sys_wr_en && (sys_wr_idx == IDX)) begin
            byte_q <= sys_wr_data;
         end
      end

      assign regs[gi] = byte_q;
   end

   assign sys_rd_data = regs[sys_rd_idx];
   assign sda_oe      = sda_oe_q;
   assign busy        = busy_q;
   assign i2c_wr_stb  = wr_stb_q;
   assign i2c_wr_idx  = wr_idx_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C controller model on an open-drain SDA line,
// vector table plus hand-written corner sequences, scoreboard queues for ACKs/reads/strobes.
`timescale 1ns/1ps
module tb_i2c_target_regs;

   localparam int T = 12;   // clk per SCL phase
   localparam int H = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe;
   logic       sys_wr_en = 1'b0;
   logic [2:0] sys_wr_idx = 3'd0;
   logic [7:0] sys_wr_data = 8'd0;
   logic [2:0] sys_rd_idx = 3'd0;
   logic [7:0] sys_rd_data;
   logic       i2c_wr_stb;
   logic [2:0] i2c_wr_idx;
   logic       busy;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_regs dut (
      .clk         (clk),
      .reset       (reset),
      .scl_in      (scl_m),
      .sda_in      (sda_line),
      .sda_oe      (sda_oe),
      .sys_wr_en   (sys_wr_en),
      .sys_wr_idx  (sys_wr_idx),
      .sys_wr_data (sys_wr_data),
      .sys_rd_idx  (sys_rd_idx),
      .sys_rd_data (sys_rd_data),
      .i2c_wr_stb  (i2c_wr_stb),
      .i2c_wr_idx  (i2c_wr_idx),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD, OP_SYSW, OP_SYSR} op_t;
   // WR: data sent, flag = expected ACK bit, stb/idx = expected commit
   // RD: data expected, flag = bit the controller returns (1 = NACK)
   // SYSW/SYSR: idx/data written or expected on sys_rd_data
   typedef struct {
      op_t        op;
      logic [7:0] data;
      logic [2:0] idx;
      logic       flag;
      logic       stb;
   } vec_t;

   vec_t       tbl[$];
   logic       exp_ack_q[$];
   logic [7:0] exp_rd_q[$];
   logic [2:0] exp_stb_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int oe_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Count cycles in which the target pulls SDA
   always @(posedge clk) begin
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   // Strobe monitor: every pulse must match the next queued commit index
   always @(negedge clk) begin
      if (!reset && i2c_wr_stb) begin
         if (exp_stb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stb_unexpected: got idx %0d, expected no strobe", i2c_wr_idx);
         end else begin
            check("stb_idx", i2c_wr_idx, exp_stb_q.pop_front());
         end
      end
   end

   task automatic i2c_start();
      sda_m = 1'b1;
      clk_wait(H);
      scl_m = 1'b1;
      clk_wait(T);
      sda_m = 1'b0;
      clk_wait(T);
      scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      clk_wait(H);
      sda_m = 1'b0;
      clk_wait(H);
      scl_m = 1'b1;
      clk_wait(T);
      sda_m = 1'b1;
      clk_wait(T);
   endtask

   // Write one byte; optionally fire an on-chip write aligned with the 8th-bit commit
   task automatic i2c_wr(input logic [7:0] b, input bit col, input logic [2:0] cidx,
                         input logic [7:0] cdat, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         clk_wait(H);
         sda_m = b[i];
         clk_wait(H);
         scl_m = 1'b1;
         if (col && i == 0) begin
            clk_wait(2);
            sys_wr_en   = 1'b1;
            sys_wr_idx  = cidx;
            sys_wr_data = cdat;
            clk_wait(1);
            sys_wr_en   = 1'b0;
            clk_wait(T - 3);
         end else begin
            clk_wait(T);
         end
         scl_m = 1'b0;
      end
      sda_m = 1'b1;
      clk_wait(T);
      scl_m = 1'b1;
      clk_wait(H);
      ack = sda_line;
      clk_wait(H);
      scl_m = 1'b0;
   endtask

   task automatic i2c_rd(input logic nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1;
         clk_wait(T);
         scl_m = 1'b1;
         clk_wait(H);
         d[i] = sda_line;
         clk_wait(H);
         scl_m = 1'b0;
      end
      clk_wait(H);
      sda_m = nack;
      clk_wait(H);
      scl_m = 1'b1;
      clk_wait(T);
      scl_m = 1'b0;
   endtask

   task automatic add(input op_t op, input logic [7:0] d, input logic [2:0] i,
                      input logic f, input logic s);
      vec_t r;
      r.op = op; r.data = d; r.idx = i; r.flag = f; r.stb = s;
      tbl.push_back(r);
   endtask

   task automatic wr_sb(input logic [7:0] b, input logic exp_ack);
      logic ack;
      exp_ack_q.push_back(exp_ack);
      i2c_wr(b, 1'b0, 3'd0, 8'd0, ack);
      check($sformatf("ack_byte_%02h", b), ack, exp_ack_q.pop_front());
   endtask

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic       ack;
      logic [7:0] got;
      int         oe0;

      // Vector table: burst write with wrap, sys readback, read with repeated START
      add(OP_START, 8'h00, 3'd0, 1'b0, 1'b0);
      add(OP_WR,    8'h84, 3'd0, 1'b0, 1'b0);
      add(OP_WR,    8'h06, 3'd0, 1'b0, 1'b0);
      add(OP_WR,    8'hA5, 3'd6, 1'b0, 1'b1);
      add(OP_WR,    8'h5A, 3'd7, 1'b0, 1'b1);
      add(OP_WR,    8'h3C, 3'd0, 1'b0, 1'b1);
      add(OP_STOP,  8'h00, 3'd0, 1'b0, 1'b0);
      add(OP_SYSR,  8'hA5, 3'd6, 1'b0, 1'b0);
      add(OP_SYSR,  8'h5A, 3'd7, 1'b0, 1'b0);
      add(OP_SYSR,  8'h3C, 3'd0, 1'b0, 1'b0);
      add(OP_SYSR,  8'h00, 3'd1, 1'b0, 1'b0);
      add(OP_START, 8'h00, 3'd0, 1'b0, 1'b0);
      add(OP_WR,    8'h84, 3'd0, 1'b0, 1'b0);
      add(OP_WR,    8'h06, 3'd0, 1'b0, 1'b0);
      add(OP_START, 8'h00, 3'd0, 1'b0, 1'b0);
      add(OP_WR,    8'h85, 3'd0, 1'b0, 1'b0);
      add(OP_RD,    8'hA5, 3'd0, 1'b0, 1'b0);
      add(OP_RD,    8'h5A, 3'd0, 1'b1, 1'b0);
      add(OP_STOP,  8'h00, 3'd0, 1'b0, 1'b0);
      add(OP_START, 8'h00, 3'd0, 1'b0, 1'b0);  // pointer wrapped to 0
      add(OP_WR,    8'h85, 3'd0, 1'b0, 1'b0);
      add(OP_RD,    8'h3C, 3'd0, 1'b1, 1'b0);
      add(OP_STOP,  8'h00, 3'd0, 1'b0, 1'b0);
      add(OP_SYSW,  8'h11, 3'd3, 1'b0, 1'b0);
      add(OP_SYSR,  8'h11, 3'd3, 1'b0, 1'b0);

      // Reset state
      clk_wait(4);
      reset = 1'b0;
      clk_wait(2);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_stb", i2c_wr_stb, 0);
      check("rst_idx", i2c_wr_idx, 0);
      for (int i = 0; i < 8; i++) begin
         sys_rd_idx = 3'(i);
         #1;
         check($sformatf("rst_reg%0d", i), sys_rd_data, 0);
      end

      // Address match and mismatch
      i2c_start();
      wr_sb(8'h84, 1'b0);
      check("busy_after_ack", busy, 1);
      i2c_stop();
      check("busy_after_stop", busy, 0);
      oe0 = oe_cnt;
      i2c_start();
      wr_sb(8'h86, 1'b1);
      check("busy_other_addr", busy, 0);
      i2c_stop();
      check("oe_cycles_other_addr", oe_cnt - oe0, 0);

      // Table
      foreach (tbl[k]) begin
         case (tbl[k].op)
            OP_START: i2c_start();
            OP_STOP:  i2c_stop();
            OP_WR: begin
               if (tbl[k].stb) exp_stb_q.push_back(tbl[k].idx);
               wr_sb(tbl[k].data, tbl[k].flag);
            end
            OP_RD: begin
               exp_rd_q.push_back(tbl[k].data);
               i2c_rd(tbl[k].flag, got);
               check($sformatf("rd_vec%0d", k), got, exp_rd_q.pop_front());
               if (tbl[k].flag) begin
                  clk_wait(H);
                  check("oe_after_nack", sda_oe, 0);
                  check("busy_after_nack", busy, 0);
               end
            end
            OP_SYSW: begin
               sys_wr_en   = 1'b1;
               sys_wr_idx  = tbl[k].idx;
               sys_wr_data = tbl[k].data;
               clk_wait(1);
               sys_wr_en   = 1'b0;
            end
            OP_SYSR: begin
               sys_rd_idx = tbl[k].idx;
               #1;
               check($sformatf("sysrd_vec%0d", k), sys_rd_data, tbl[k].data);
            end
            default: ;
         endcase
      end

      // Collision: same index (I2C wins), then different index (both land)
      i2c_start();
      wr_sb(8'h84, 1'b0);
      wr_sb(8'h03, 1'b0);
      exp_stb_q.push_back(3'd3);
      i2c_wr(8'h22, 1'b1, 3'd3, 8'h11, ack);
      check("ack_col_same", ack, 0);
      exp_stb_q.push_back(3'd4);
      i2c_wr(8'h33, 1'b1, 3'd5, 8'h77, ack);
      check("ack_col_diff", ack, 0);
      i2c_stop();
      sys_rd_idx = 3'd3; #1; check("col_reg3", sys_rd_data, 8'h22);
      sys_rd_idx = 3'd4; #1; check("col_reg4", sys_rd_data, 8'h33);
      sys_rd_idx = 3'd5; #1; check("col_reg5", sys_rd_data, 8'h77);

      // Abort: STOP after 4 data bits
      i2c_start();
      wr_sb(8'h84, 1'b0);
      wr_sb(8'h03, 1'b0);
      for (int i = 0; i < 4; i++) begin
         clk_wait(H);
         sda_m = 1'b1;
         clk_wait(H);
         scl_m = 1'b1;
         clk_wait(T);
         scl_m = 1'b0;
      end
      i2c_stop();
      clk_wait(T);
      check("abort_busy", busy, 0);
      check("abort_oe", sda_oe, 0);
      sys_rd_idx = 3'd3; #1; check("abort_reg3", sys_rd_data, 8'h22);

      // Reset while driving a read bit (reg3 = 0x22, MSB 0 -> SDA pulled)
      i2c_start();
      wr_sb(8'h85, 1'b0);
      clk_wait(6);
      check("rd_bit7_driven", sda_oe, 1);
      reset = 1'b1;
      clk_wait(1);
      check("rst_mid_oe", sda_oe, 0);
      check("rst_mid_busy", busy, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sys_rd_idx = 3'(i);
         #1;
         check($sformatf("rst_mid_reg%0d", i), sys_rd_data, 0);
      end
      i2c_stop();

      // Bus usable again after reset
      i2c_start();
      wr_sb(8'h84, 1'b0);
      wr_sb(8'h02, 1'b0);
      exp_stb_q.push_back(3'd2);
      wr_sb(8'h99, 1'b0);
      i2c_stop();
      sys_rd_idx = 3'd2; #1; check("post_rst_reg2", sys_rd_data, 8'h99);

      clk_wait(4);
      check("stb_queue_drained", exp_stb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
